// File: rtl/vx_rop_arb_pkg.sv
// Shared ROP types: colour, fragment request bundle and arbiter defaults.
// Imported by the ROP arbiter, its round-robin sub-module and benches.
package vx_rop_arb_pkg;

    localparam int ROP_DEF_NUM_REQS  = 4;
    localparam int ROP_DEF_PEND_SIZE = 8;

    localparam int ROP_RT_BITS    = 2;
    localparam int ROP_POS_BITS   = 12;
    localparam int ROP_DEPTH_BITS = 24;
    localparam int ROP_MASK_BITS  = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgba_t;

    typedef struct packed {
        logic [ROP_RT_BITS-1:0]    rt_idx;
        logic [ROP_POS_BITS-1:0]   pos_x;
        logic [ROP_POS_BITS-1:0]   pos_y;
        logic [ROP_DEPTH_BITS-1:0] depth;
        rgba_t                     color;
        logic [ROP_MASK_BITS-1:0]  sample_mask;
    } rop_req_t;

    localparam int ROP_REQ_BITS = $bits(rop_req_t);

endpackage

// File: rtl/vx_rop_rr_arbiter.sv
// Round-robin pick: first set bit of elig at or after ptr, wrapping.
// Ports: elig/ptr in; one-hot grant, winner idx and valid out.
module vx_rop_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && elig[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/vx_rop_arb.sv
// ROP fragment arbiter: serialises per-core fragments into the ROP pipe
// while blocking any fragment whose (x,y) is already in flight.
// Ports: req_valid/req_data/req_ready per core; out_valid/out_data/out_tag/
// out_ready to the pipe; done_valid/done_tag retire slots; pending, idle.
module vx_rop_arb
    import vx_rop_arb_pkg::*;
#(
    parameter int NUM_REQS  = ROP_DEF_NUM_REQS,
    parameter int PEND_SIZE = ROP_DEF_PEND_SIZE,
    localparam int TAG_BITS = $clog2(PEND_SIZE),
    localparam int REQ_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  rop_req_t [NUM_REQS-1:0]   req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output rop_req_t                  out_data,
    output logic [TAG_BITS-1:0]       out_tag,
    input  logic                      out_ready,
    input  logic                      done_valid,
    input  logic [TAG_BITS-1:0]       done_tag,
    output logic [TAG_BITS:0]         pending,
    output logic                      idle
);

    logic [PEND_SIZE-1:0]                   tbl_valid;
    logic [PEND_SIZE-1:0][ROP_POS_BITS-1:0] tbl_x;
    logic [PEND_SIZE-1:0][ROP_POS_BITS-1:0] tbl_y;
    logic [REQ_BITS-1:0]                    rr_ptr;
    logic [TAG_BITS:0]                      pend_cnt;

    logic [NUM_REQS-1:0] hit;
    logic [NUM_REQS-1:0] elig;
    logic [NUM_REQS-1:0] grant;
    logic [REQ_BITS-1:0] win_idx;
    logic                win_valid;
    logic                free_any;
    logic [TAG_BITS-1:0] free_idx;
    logic                can_grant;
    logic                done_ok;
    rop_req_t            win_req;

    // Conflict check against the pre-edge table only; a slot retiring
    // this cycle still blocks its position until the next cycle.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            for (int s = 0; s < PEND_SIZE; s++) begin
                if (tbl_valid[s]
                    && tbl_x[s] == req_data[i].pos_x
                    && tbl_y[s] == req_data[i].pos_y) begin
                    hit[i] = 1'b1;
                end
            end
        end
    end

    // Descending scan so the last write is the lowest free slot.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int s = PEND_SIZE - 1; s >= 0; s--) begin
            if (!tbl_valid[s]) begin
                free_any = 1'b1;
                free_idx = TAG_BITS'(s);
            end
        end
    end

    assign can_grant = free_any && (!out_valid || out_ready);
    assign elig      = can_grant ? (req_valid & ~hit) : '0;

    vx_rop_rr_arbiter #(
        .N  (NUM_REQS),
        .IW (REQ_BITS)
    ) u_rr (
        .elig  (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign req_ready = grant;
    assign win_req   = req_data[win_idx];
    assign done_ok   = done_valid && tbl_valid[done_tag];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_valid <= '0;
            tbl_x     <= '0;
            tbl_y     <= '0;
        end else begin
            if (done_ok) begin
                tbl_valid[done_tag] <= 1'b0;
            end
            if (win_valid) begin
                tbl_valid[free_idx] <= 1'b1;
                tbl_x[free_idx]     <= win_req.pos_x;
                tbl_y[free_idx]     <= win_req.pos_y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_cnt <= '0;
        end else begin
            unique case ({win_valid, done_ok})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (win_valid) begin
            if (win_idx == REQ_BITS'(NUM_REQS - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= win_idx + REQ_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (win_valid) begin
            out_valid <= 1'b1;
            out_data  <= win_req;
            out_tag   <= free_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign pending = pend_cnt;
    assign idle    = (pend_cnt == '0) && !out_valid;

    // Retiring a slot that is not in flight is a pipeline bug upstream.
    always @(posedge clk) begin
        if (reset_n && done_valid) begin
            assert (tbl_valid[done_tag])
            else $warning("done_tag %0d retires an empty slot", done_tag);
        end
    end

endmodule

// File: tb/tb_vx_rop_arb.sv
// Scoreboard bench for vx_rop_arb: grant order, slot allocation,
// position blocking, back-pressure, retire corner cases and reset.
module tb_vx_rop_arb;
    import vx_rop_arb_pkg::*;

    logic              clk;
    logic              reset_n;
    logic [3:0]        req_valid;
    rop_req_t [3:0]    req_data;
    logic [3:0]        req_ready;
    logic              out_valid;
    rop_req_t          out_data;
    logic [2:0]        out_tag;
    logic              out_ready;
    logic              done_valid;
    logic [2:0]        done_tag;
    logic [3:0]        pending;
    logic              idle;

    typedef struct {
        rop_req_t   d;
        logic [2:0] t;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    vx_rop_arb #(
        .NUM_REQS  (4),
        .PEND_SIZE (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_ready  (out_ready),
        .done_valid (done_valid),
        .done_tag   (done_tag),
        .pending    (pending),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rop_req_t mk(input int x, input int y, input int s);
        rop_req_t r;
        r.rt_idx      = 2'(s);
        r.pos_x       = 12'(x);
        r.pos_y       = 12'(y);
        r.depth       = 24'(s * 77 + x);
        r.color       = rgba_t'(32'(x * 1031 + y * 7 + s));
        r.sample_mask = 4'(s + 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration cycle: check req_ready, push the expected winner,
    // then drop the requests that were actually accepted.
    task automatic step(input logic [3:0] exp_rdy, input int exp_tag);
        logic [3:0] got;
        exp_t       e;
        @(negedge clk);
        got = req_ready;
        chk("req_ready", 128'(got), 128'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                e.d = req_data[i];
                e.t = 3'(exp_tag);
                sb.push_back(e);
            end
        end
        tick();
        req_valid = req_valid & ~got;
    endtask

    task automatic retire(input int t);
        done_valid = 1'b1;
        done_tag   = 3'(t);
        tick();
        done_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 128'(1), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("out_data", 128'(out_data), 128'(e.d));
                chk("out_tag", 128'(out_tag), 128'(e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        out_ready  = 1'b1;
        done_valid = 1'b0;
        done_tag   = '0;
        #2;
        chk("rst_pending", 128'(pending), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_tag", 128'(out_tag), 128'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Four distinct requesters granted back to back.
        for (int i = 0; i < 4; i++) req_data[i] = mk(i * 3 + 1, 20 + i, i);
        req_valid = 4'b1111;
        step(4'b0001, 0);
        step(4'b0010, 1);
        step(4'b0100, 2);
        step(4'b1000, 3);
        chk("a_pending", 128'(pending), 128'(4));
        for (int t = 0; t < 4; t++) retire(t);
        chk("a_pending_0", 128'(pending), 128'(0));
        chk("a_idle", 128'(idle), 128'(1));

        // Position conflict: requester 1 waits for (5,7) to retire.
        req_data[0] = mk(5, 7, 10);
        req_valid   = 4'b0001;
        step(4'b0001, 0);
        req_data[1] = mk(5, 7, 11);
        req_data[2] = mk(1, 1, 12);
        req_valid   = 4'b0110;
        step(4'b0100, 1);
        step(4'b0000, 0);
        step(4'b0000, 0);
        done_valid = 1'b1;
        done_tag   = 3'd0;
        step(4'b0000, 0);
        done_valid = 1'b0;
        step(4'b0010, 0);
        retire(0);
        retire(1);
        chk("b_pending", 128'(pending), 128'(0));

        // Fill all eight slots, then one retire reopens slot 3.
        for (int k = 0; k < 8; k++) begin
            req_data[0] = mk(100 + k, 50, k);
            req_valid   = 4'b0001;
            step(4'b0001, k);
        end
        req_data[0] = mk(108, 50, 8);
        req_data[1] = mk(109, 50, 9);
        req_valid   = 4'b0011;
        step(4'b0000, 0);
        step(4'b0000, 0);
        chk("c_pending_full", 128'(pending), 128'(8));
        done_valid = 1'b1;
        done_tag   = 3'd3;
        step(4'b0000, 0);
        done_valid = 1'b0;
        step(4'b0010, 3);
        step(4'b0000, 0);
        req_valid = '0;
        for (int t = 0; t < 8; t++) retire(t);
        chk("c_pending_0", 128'(pending), 128'(0));

        // Back-pressure holds the output register and stops grants.
        for (int i = 0; i < 4; i++) req_data[i] = mk(200 + i, 60, 20 + i);
        req_valid = 4'b1111;
        step(4'b0100, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(4'b0000, 0);
            chk("d_hold_valid", 128'(out_valid), 128'(1));
            chk("d_hold_tag", 128'(out_tag), 128'(0));
            chk("d_hold_data", 128'(out_data), 128'(req_data[2]));
        end
        out_ready = 1'b1;
        step(4'b1000, 1);
        step(4'b0001, 2);
        step(4'b0010, 3);
        chk("d_pending", 128'(pending), 128'(4));

        // Same-cycle retire and grant, then a retire of an empty slot.
        req_data[0] = mk(300, 70, 30);
        req_valid   = 4'b0001;
        done_valid  = 1'b1;
        done_tag    = 3'd2;
        step(4'b0001, 4);
        done_valid = 1'b0;
        chk("e_pending_same", 128'(pending), 128'(4));
        retire(2);
        chk("e_pending_bad", 128'(pending), 128'(4));
        req_data[1] = mk(301, 70, 31);
        req_valid   = 4'b0010;
        step(4'b0010, 2);
        chk("e_pending_5", 128'(pending), 128'(5));
        chk("e_out_valid", 128'(out_valid), 128'(1));

        // Asynchronous reset mid-stream.
        #2;
        reset_n = 1'b0;
        #1;
        chk("f_pending", 128'(pending), 128'(0));
        chk("f_out_valid", 128'(out_valid), 128'(0));
        chk("f_idle", 128'(idle), 128'(1));
        chk("f_out_data", 128'(out_data), 128'(0));
        sb.delete();
        tick();
        reset_n = 1'b1;
        retire(0);
        chk("f_stale_done", 128'(pending), 128'(0));
        req_data[0] = mk(400, 80, 40);
        req_data[3] = mk(401, 80, 41);
        req_valid   = 4'b1001;
        step(4'b0001, 0);
        step(4'b1000, 1);
        tick();
        tick();
        chk("f_pending_2", 128'(pending), 128'(2));
        chk("f_sb_drained", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
